// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types for the core clock power manager
package cv32e40p_pkg;
  typedef enum logic [1:0] {
    PM_ACTIVE = 2'd0,
    PM_ENTRY  = 2'd1,
    PM_GATED  = 2'd2,
    PM_RESUME = 2'd3
  } pm_state_e;
endpackage

// File: rtl/cv32e40p_pm_sat_counter.sv
// cv32e40p_pm_sat_counter: saturating up-counter with priority synchronous clear
module cv32e40p_pm_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);
  // Clear beats increment; increment stops at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_o <= '0;
    else if (clr_i) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + WIDTH'(1);
endmodule

// File: rtl/cv32e40p_core_clk_pm.sv
// cv32e40p_core_clk_pm: SoC-level clock gating of the core around core_sleep_o
module cv32e40p_core_clk_pm
  import cv32e40p_pkg::*;
#(
  parameter int IRQ_W         = 32,
  parameter int DLY_W         = 8,
  parameter int RESUME_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk_ungated_i,
  input  logic             rst_n,
  input  logic             core_sleep_i,
  input  logic [IRQ_W-1:0] irq_i,
  input  logic [IRQ_W-1:0] irq_wake_mask_i,
  input  logic             debug_req_i,
  input  logic             sleep_en_i,
  input  logic [DLY_W-1:0] entry_delay_i,
  input  logic             clr_cycles_i,
  output logic             core_clk_en_o,
  output logic [1:0]       pm_state_o,
  output logic             wake_event_o,
  output logic [CNT_W-1:0] sleep_cycles_o
);
  localparam int RW = RESUME_CYCLES > 1 ? $clog2(RESUME_CYCLES) : 1;
  pm_state_e        state, state_n;
  logic [DLY_W-1:0] dly_cnt, dly_n;
  logic [RW-1:0]    rsm_cnt, rsm_n;
  logic             wake;
  assign wake       = |(irq_i & irq_wake_mask_i) | debug_req_i;
  assign pm_state_o = state;
  // Next state and counter updates; at most one transition per cycle
  always_comb begin
    state_n = state;
    dly_n   = dly_cnt;
    rsm_n   = rsm_cnt;
    case (state)
      PM_ACTIVE:
        if (sleep_en_i && core_sleep_i && !wake) begin
          state_n = PM_ENTRY;
          dly_n   = entry_delay_i;
        end
      PM_ENTRY:
        if (!core_sleep_i || wake || !sleep_en_i) state_n = PM_ACTIVE;
        else if (dly_cnt == '0) state_n = PM_GATED;
        else dly_n = dly_cnt - DLY_W'(1);
      PM_GATED:
        if (wake || !core_sleep_i || !sleep_en_i) begin
          state_n = PM_RESUME;
          rsm_n   = RW'(RESUME_CYCLES - 1);
        end
      PM_RESUME:
        if (rsm_cnt == '0) state_n = PM_ACTIVE;
        else rsm_n = rsm_cnt - RW'(1);
      default: state_n = PM_ACTIVE;
    endcase
  end
  // Enable and wake pulse are registered from next state so the gate sees a clean flop output
  always_ff @(posedge clk_ungated_i or negedge rst_n)
    if (!rst_n) begin
      state         <= PM_ACTIVE;
      dly_cnt       <= '0;
      rsm_cnt       <= '0;
      core_clk_en_o <= 1'b1;
      wake_event_o  <= 1'b0;
    end else begin
      state         <= state_n;
      dly_cnt       <= dly_n;
      rsm_cnt       <= rsm_n;
      core_clk_en_o <= state_n != PM_GATED;
      wake_event_o  <= state == PM_GATED && state_n == PM_RESUME;
    end
  cv32e40p_pm_sat_counter #(.WIDTH(CNT_W)) u_sleep_cnt (
    .clk   (clk_ungated_i),
    .rst_n (rst_n),
    .inc_i (state == PM_GATED),
    .clr_i (clr_cycles_i),
    .cnt_o (sleep_cycles_o)
  );
endmodule

// File: doc/cv32e40p_core_clk_pm.md
Name: cv32e40p_core_clk_pm

Overview:
SoC-side power manager directly downstream of the core sleep logic. It consumes the core's core_sleep_o and, after a programmable entry delay, deasserts an enable that gates the core's clk_i at SoC level. It re-enables the clock on wake events (irq, debug request, sleep exit, or config disable) and guarantees a minimum resume window. It also keeps a saturating count of gated cycles for software power accounting.

Parameters:
IRQ_W, 32, width of irq / wake-mask vectors
DLY_W, 8, width of entry-delay counter
RESUME_CYCLES, 2, cycles held in RESUME before returning to ACTIVE (>=1)
CNT_W, 32, width of sleep-cycle counter

Ports:
clk_ungated_i  input  1  free-running SoC clock; never gated by this block
rst_n  input  1  asynchronous active-low reset
core_sleep_i  input  1  core sleep indication (core_sleep_o of core)
irq_i  input  IRQ_W  raw core interrupt lines
irq_wake_mask_i  input  IRQ_W  1 = line may wake core
debug_req_i  input  1  debug request to core
sleep_en_i  input  1  config: external gating permitted
entry_delay_i  input  DLY_W  extra ACTIVE-to-GATED hysteresis cycles
clr_cycles_i  input  1  synchronous clear of sleep-cycle counter
core_clk_en_o  output  1  registered enable for SoC clock gate on core clk_i
pm_state_o  output  2  current FSM state encoding
wake_event_o  output  1  one-cycle pulse on GATED->RESUME
sleep_cycles_o  output  CNT_W  saturating count of gated cycles

Behaviour:
- Clock clk_ungated_i; reset rst_n, asynchronous, active-low.
- Reset values: state ACTIVE, core_clk_en_o=1, wake_event_o=0, sleep_cycles_o=0, delay counter 0, resume counter 0.
- wake = |(irq_i & irq_wake_mask_i) | debug_req_i. Combinational use only; inputs are already synchronous to clk_ungated_i.
- States: ACTIVE=2'd0, ENTRY=2'd1, GATED=2'd2, RESUME=2'd3.
- ACTIVE:
  - If sleep_en_i & core_sleep_i & !wake: go to ENTRY and load dly_cnt <= entry_delay_i.
  - core_clk_en_o=1.
- ENTRY:
  - Abort to ACTIVE if !core_sleep_i | wake | !sleep_en_i. Abort has priority.
  - Else if dly_cnt==0: go to GATED.
  - Else dly_cnt decrements.
  - ENTRY therefore lasts entry_delay_i+1 cycles, and core_clk_en_o is first 0 in the first GATED cycle.
  - entry_delay_i is sampled only on ACTIVE->ENTRY; later changes are ignored.
- GATED:
  - core_clk_en_o=0.
  - Exit to RESUME if wake | !core_sleep_i | !sleep_en_i, whichever comes first.
  - On exit: core_clk_en_o=1 from the first RESUME cycle, wake_event_o=1 for that one cycle, rst_cnt <= RESUME_CYCLES-1.
- RESUME:
  - core_clk_en_o=1. core_sleep_i and wake are ignored.
  - Goes to ACTIVE when rst_cnt==0, else rst_cnt decrements. Duration is exactly RESUME_CYCLES cycles.
- sleep_cycles_o:
  - +1 on each cycle with state==GATED; saturates at all-ones (no wrap).
  - clr_cycles_i wins over increment; a simultaneous clear and increment yields 0.
- Never more than one transition per cycle. Reset mid-GATED immediately re-enables the clock (core_clk_en_o=1 asynchronously).
- core_clk_en_o comes straight from a flop (glitch-free). The external clock gate latches it.

Decomposition:
- cv32e40p_pkg gets pm_state_e (2-bit enum with the encodings above).
- One sub-module: cv32e40p_pm_sat_counter (parameter WIDTH; ports clk, rst_n, inc_i, clr_i, cnt_o), used for sleep_cycles_o.
- The FSM and the delay/resume counters stay in the top module.

Test Plan:
1. Reset, then core_sleep_i=1, sleep_en_i=1, entry_delay_i=3, no wake -> ENTRY for 4 cycles; core_clk_en_o=0 in cycle 5; pm_state_o=2.
2. In GATED, assert irq_i[7] with mask[7]=1 after 10 gated cycles -> next cycle state RESUME, core_clk_en_o=1, wake_event_o pulses once; sleep_cycles_o=10; ACTIVE after RESUME_CYCLES=2 cycles.
3. In ENTRY with entry_delay_i=5, drop core_sleep_i at count 2 -> ACTIVE next cycle; core_clk_en_o never 0; sleep_cycles_o unchanged.
4. In GATED, masked irq (mask=0) then debug_req_i=1 -> no exit on irq; exit to RESUME on debug_req_i; sleep_en_i=0 while in GATED also forces RESUME.
5. Preload via long sleep with CNT_W=4 -> counter stops at 15; clr_cycles_i=1 together with a GATED cycle -> 0.
6. Assert rst_n=0 during GATED -> core_clk_en_o=1 immediately; state ACTIVE; counter 0.
